// File: rtl/key_sw_input_unit_if.sv
// Load/store bus between the processor datapath and the KEY/SW input unit.
// The master issues the address and the read and write strobes. The slave
// returns combinational read data in the same cycle.
interface key_sw_input_unit_if;
   logic [31:0] addr;
   logic        rdEn;
   logic        wrEn;
   logic [31:0] wrData;
   logic [31:0] rdData;

   modport master (
      output addr,
      output rdEn,
      output wrEn,
      output wrData,
      input  rdData
   );

   modport slave (
      input  addr,
      input  rdEn,
      input  wrEn,
      input  wrData,
      output rdData
   );
endinterface

// File: rtl/key_sw_input_unit.sv
// Memory-mapped KEY/SW input peripheral.
// Each raw pin passes through a two-flop synchronizer and then a per-bit
// debouncer. KEY presses (a 1->0 change of the debounced level) set sticky
// capture flags. Software polls these flags and clears them with a
// write-1-to-clear store.
module key_sw_input_unit #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_BITS        = 16,
   parameter logic [31:0] ADDR_KEY        = 32'hF000_0010,
   parameter logic [31:0] ADDR_SW         = 32'hF000_0014,
   parameter logic [31:0] ADDR_KEY_EDGE   = 32'hF000_0018
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             KEY,
   input  logic [9:0]             SW,
   key_sw_input_unit_if.slave     busIf,
   output logic                   keyEdgeAny
);

   localparam int unsigned         NUM_BITS   = 14;
   // KEY bits idle high (released) and SW bits idle low.
   localparam logic [NUM_BITS-1:0] IDLE_LEVEL = {10'h000, 4'hF};
   localparam logic [CNT_BITS-1:0] CNT_LAST   = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BITS-1:0] rawIn;
   logic [NUM_BITS-1:0] syncA;
   logic [NUM_BITS-1:0] syncB;
   logic [NUM_BITS-1:0] stable;
   logic [NUM_BITS-1:0] stableNext;
   logic [CNT_BITS-1:0] cnt     [NUM_BITS];
   logic [CNT_BITS-1:0] cntNext [NUM_BITS];

   logic [3:0] keyStable;
   logic [9:0] swStable;
   logic [3:0] keyPress;
   logic [3:0] clearMask;
   logic [3:0] keyEdge;
   logic [3:0] keyEdgeNext;

   logic hitKey;
   logic hitSw;
   logic hitEdge;
   logic unusedWrBits;

   assign rawIn = {SW, KEY};

   // Two-flop synchronizer for every raw pin
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncA <= IDLE_LEVEL;
         syncB <= IDLE_LEVEL;
      end else begin
         syncA <= rawIn;
         syncB <= syncA;
      end
   end

   // Debounce next state: the stable level follows the synchronized level
   // only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      stableNext = stable;
      for (int unsigned i = 0; i < NUM_BITS; i++) begin
         cntNext[i] = '0;
         if (syncB[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST) begin
               stableNext[i] = syncB[i];
            end else begin
               cntNext[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= IDLE_LEVEL;
         for (int unsigned i = 0; i < NUM_BITS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable <= stableNext;
         for (int unsigned i = 0; i < NUM_BITS; i++) begin
            cnt[i] <= cntNext[i];
         end
      end
   end

   assign keyStable = stable[3:0];
   assign swStable  = stable[13:4];

   assign hitKey  = (busIf.addr == ADDR_KEY);
   assign hitSw   = (busIf.addr == ADDR_SW);
   assign hitEdge = (busIf.addr == ADDR_KEY_EDGE);

   // Only the low four store-data bits map onto capture flags.
   assign unusedWrBits = |busIf.wrData[31:4];

   // Capture-flag next state. The press is detected from the debounced
   // next state, so a flag sets on the same edge as the stable level falls.
   // OR-ing the press in after the clear lets a new press win over a
   // clear on the same bit.
   always_comb begin
      keyPress    = keyStable & ~stableNext[3:0];
      clearMask   = (busIf.wrEn && hitEdge) ? busIf.wrData[3:0] : '0;
      keyEdgeNext = (keyEdge & ~clearMask) | keyPress;
   end

   // Capture flags and the registered any-flag status
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         keyEdge    <= '0;
         keyEdgeAny <= 1'b0;
      end else begin
         keyEdge    <= keyEdgeNext;
         keyEdgeAny <= |keyEdgeNext;
      end
   end

   // Side-effect-free read mux, valid in the same cycle as addr/rdEn
   always_comb begin
      busIf.rdData = '0;
      if (busIf.rdEn) begin
         if (hitKey) begin
            busIf.rdData = {28'd0, keyStable};
         end else if (hitSw) begin
            busIf.rdData = {22'd0, swStable};
         end else if (hitEdge) begin
            busIf.rdData = {28'd0, keyEdge};
         end
      end
   end

endmodule

// File: tb/tb_key_sw_input_unit.sv
// Directed self-checking bench for key_sw_input_unit with DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_key_sw_input_unit;

   localparam logic [31:0] A_KEY  = 32'hF000_0010;
   localparam logic [31:0] A_SW   = 32'hF000_0014;
   localparam logic [31:0] A_EDGE = 32'hF000_0018;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic       keyEdgeAny;

   int checks   = 0;
   int failures = 0;

   key_sw_input_unit_if busIf ();

   key_sw_input_unit #(
      .DEBOUNCE_CYCLES (4),
      .CNT_BITS        (16),
      .ADDR_KEY        (A_KEY),
      .ADDR_SW         (A_SW),
      .ADDR_KEY_EDGE   (A_EDGE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .KEY        (KEY),
      .SW         (SW),
      .busIf      (busIf),
      .keyEdgeAny (keyEdgeAny)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Settle just after a rising edge, away from the sampling point.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      busIf.addr = a;
      busIf.rdEn = 1'b1;
      #1;
      check(tag, busIf.rdData, exp);
      busIf.rdEn = 1'b0;
   endtask

   // Store that is active across the next rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      busIf.addr   = a;
      busIf.wrData = d;
      busIf.wrEn   = 1'b1;
      tick(1);
      busIf.wrEn   = 1'b0;
      busIf.wrData = '0;
   endtask

   initial begin
      busIf.addr   = '0;
      busIf.rdEn   = 1'b0;
      busIf.wrEn   = 1'b0;
      busIf.wrData = '0;

      // Reset held with every pin in its non-idle state
      reset = 1'b0;
      KEY   = 4'h0;
      SW    = 10'h3FF;
      tick(3);
      rd("rst_key", A_KEY, 32'h0000_000F);
      rd("rst_sw", A_SW, 32'h0000_0000);
      rd("rst_edge", A_EDGE, 32'h0000_0000);
      check("rst_any", {31'd0, keyEdgeAny}, 32'd0);
      busIf.addr = A_KEY;
      #1;
      check("rst_noRdEn", busIf.rdData, 32'd0);

      KEY = 4'hF;
      SW  = 10'h000;
      tick(1);
      reset = 1'b1;
      tick(3);

      // Clean press of KEY[0]: stable falls at edge 6
      KEY = 4'b1110;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         rd($sformatf("press_key_e%0d", k), A_KEY, 32'h0000_000F);
         rd($sformatf("press_edge_e%0d", k), A_EDGE, 32'h0000_0000);
      end
      tick(1);
      rd("press_key_e6", A_KEY, 32'h0000_000E);
      rd("press_edge_e6", A_EDGE, 32'h0000_0001);
      check("press_any_e6", {31'd0, keyEdgeAny}, 32'd1);

      // Clear and release KEY[0]; the release must not set a flag
      wr(A_EDGE, 32'h0000_0001);
      rd("clr0_edge", A_EDGE, 32'h0000_0000);
      check("clr0_any", {31'd0, keyEdgeAny}, 32'd0);
      KEY = 4'hF;
      tick(8);
      rd("rel0_key", A_KEY, 32'h0000_000F);
      rd("rel0_edge", A_EDGE, 32'h0000_0000);

      // 3-cycle SW[3] glitch is rejected
      SW = 10'h008;
      tick(3);
      SW = 10'h000;
      for (int k = 0; k < 8; k++) begin
         rd($sformatf("glitch_sw_%0d", k), A_SW, 32'h0000_0000);
         tick(1);
      end

      // A held SW[3] is accepted at edge 6 and not before
      SW = 10'h008;
      tick(5);
      rd("hold_sw_e5", A_SW, 32'h0000_0000);
      tick(1);
      rd("hold_sw_e6", A_SW, 32'h0000_0008);

      // Press KEY[0] and KEY[2] together
      KEY = 4'b1010;
      tick(6);
      rd("dual_key", A_KEY, 32'h0000_000A);
      rd("dual_edge", A_EDGE, 32'h0000_0005);

      // Write-1-to-clear only bit 2
      wr(A_EDGE, 32'h0000_0004);
      rd("w1c_edge", A_EDGE, 32'h0000_0001);

      // Stores to the level addresses change nothing
      wr(A_KEY, 32'hFFFF_FFFF);
      wr(A_SW, 32'hFFFF_FFFF);
      rd("wrKey_edge", A_EDGE, 32'h0000_0001);
      rd("wrKey_key", A_KEY, 32'h0000_000A);
      rd("wrKey_sw", A_SW, 32'h0000_0008);
      check("wrKey_any", {31'd0, keyEdgeAny}, 32'd1);

      // Clear everything, then release KEY[2] with KEY[0] still held
      wr(A_EDGE, 32'h0000_000F);
      rd("clrAll_edge", A_EDGE, 32'h0000_0000);
      KEY = 4'b1110;
      tick(8);
      rd("rel2_key", A_KEY, 32'h0000_000E);
      rd("rel2_edge", A_EDGE, 32'h0000_0000);

      // KEY[1] press stabilises on the same edge as a clear of bit 1.
      // The store also reads the edge address in that cycle (pre-edge value).
      KEY = 4'b1100;
      tick(5);
      rd("coll_pre_edge", A_EDGE, 32'h0000_0000);
      busIf.addr   = A_EDGE;
      busIf.wrData = 32'h0000_0002;
      busIf.wrEn   = 1'b1;
      busIf.rdEn   = 1'b1;
      #1;
      check("coll_rdwr", busIf.rdData, 32'h0000_0000);
      tick(1);
      busIf.wrEn   = 1'b0;
      busIf.rdEn   = 1'b0;
      busIf.wrData = '0;
      rd("coll_edge", A_EDGE, 32'h0000_0002);
      rd("coll_key", A_KEY, 32'h0000_000C);
      check("coll_any", {31'd0, keyEdgeAny}, 32'd1);

      // Unmapped and partially matching addresses read zero
      rd("unmapped_1C", 32'hF000_001C, 32'h0000_0000);
      rd("unmapped_hi", 32'h7000_0010, 32'h0000_0000);

      // Asynchronous reset mid-cycle with KEY[1:0] held pressed
      #2;
      reset = 1'b0;
      #1;
      rd("arst_key", A_KEY, 32'h0000_000F);
      rd("arst_edge", A_EDGE, 32'h0000_0000);
      check("arst_any", {31'd0, keyEdgeAny}, 32'd0);
      tick(2);
      reset = 1'b1;
      tick(5);
      rd("post_rst_key_e5", A_KEY, 32'h0000_000F);
      rd("post_rst_edge_e5", A_EDGE, 32'h0000_0000);
      tick(1);
      rd("post_rst_key_e6", A_KEY, 32'h0000_000C);
      rd("post_rst_edge_e6", A_EDGE, 32'h0000_0003);
      check("post_rst_any", {31'd0, keyEdgeAny}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
